// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: instruction class encodings,
// instruction field bit positions, skid-buffer states and the decoded-entry
// struct carried through the buffer.
package decode_stage_pkg;

  // Widest DATA_W supported; entries carry label/immediate at this width.
  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned OPC_W      = 8;
  localparam int unsigned FIELD_W    = 5;

  // Instruction field bit positions.
  localparam int unsigned CLS_HI  = 31;
  localparam int unsigned CLS_LO  = 29;
  localparam int unsigned RA_HI   = 28;
  localparam int unsigned RA_LO   = 24;
  localparam int unsigned RB_HI   = 23;
  localparam int unsigned RB_LO   = 19;
  localparam int unsigned FN_HI   = 18;
  localparam int unsigned FN_LO   = 16;
  localparam int unsigned FN4_LO  = 15;
  localparam int unsigned IMM_HI  = 15;
  localparam int unsigned JL_HI   = 28;
  localparam int unsigned JL_LO   = 3;
  localparam int unsigned JOP_HI  = 2;
  localparam int unsigned BOP_HI  = 23;
  localparam int unsigned BOP_LO  = 22;
  localparam int unsigned BL_HI   = 21;

  typedef enum logic [2:0] {
    CLS_RTYPE  = 3'b000,
    CLS_ITYPE  = 3'b001,
    CLS_STYPE  = 3'b010,
    CLS_JUMP   = 3'b011,
    CLS_BRANCH = 3'b100,
    CLS_RJUMP  = 3'b101,
    CLS_RSVD6  = 3'b110,
    CLS_RSVD7  = 3'b111
  } cls_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [OPC_W-1:0]      opcode;
    logic [FIELD_W-1:0]    reg1;
    logic [FIELD_W-1:0]    reg2;
    logic [MAX_DATA_W-1:0] label;
    logic [MAX_DATA_W-1:0] immediate;
    logic                  illegal;
  } entry_t;

endpackage

// File: rtl/decode_stage_fields.sv
// decode_fields: pure combinational class/field extraction.
// Ports: instr (32b instruction), rs_val (register value for the
// register-jump class), ent_c (decoded entry).
// Macro DECODE_ILLEGAL_TRAP_EN: reserved classes 110/111 decode as a trap
// entry (illegal=1, opcode[7:5]=class) instead of an all-zero NOP.
module decode_fields
  import decode_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter bit          IMM_SEXT = 1'b1
) (
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_val,
  output entry_t            ent_c
);

  logic [2:0]            cls;
  logic [MAX_DATA_W-1:0] imm_ext;

  assign cls = instr[CLS_HI:CLS_LO];

  // Extending to the maximum width then truncating at the output gives the
  // same result as extending straight to DATA_W.
  assign imm_ext = IMM_SEXT ? {{(MAX_DATA_W-16){instr[IMM_HI]}}, instr[IMM_HI:0]}
                            : {{(MAX_DATA_W-16){1'b0}}, instr[IMM_HI:0]};

  always_comb begin
    ent_c = '0;
    case (cls)
      CLS_RTYPE: begin
        ent_c.reg1   = instr[RA_HI:RA_LO];
        ent_c.reg2   = instr[RB_HI:RB_LO];
        ent_c.opcode = {4'b0000, instr[FN_HI:FN4_LO]};
      end
      CLS_ITYPE: begin
        ent_c.reg1      = instr[RA_HI:RA_LO];
        ent_c.opcode    = {cls, 2'b00, instr[FN_HI:FN_LO]};
        ent_c.immediate = imm_ext;
      end
      CLS_STYPE: begin
        ent_c.reg2      = instr[RA_HI:RA_LO];
        ent_c.reg1      = instr[RB_HI:RB_LO];
        ent_c.opcode    = {cls, 2'b00, instr[FN_HI:FN_LO]};
        ent_c.immediate = imm_ext;
      end
      CLS_JUMP: begin
        ent_c.reg1   = 5'd31;
        ent_c.label  = MAX_DATA_W'(instr[JL_HI:JL_LO]);
        ent_c.opcode = {cls, 2'b00, instr[JOP_HI:0]};
      end
      CLS_BRANCH: begin
        ent_c.reg1   = instr[RA_HI:RA_LO];
        ent_c.label  = MAX_DATA_W'(instr[BL_HI:0]);
        ent_c.opcode = {cls, 3'b000, instr[BOP_HI:BOP_LO]};
      end
      CLS_RJUMP: begin
        ent_c.reg1   = instr[RA_HI:RA_LO];
        ent_c.label  = MAX_DATA_W'(rs_val);
        ent_c.opcode = {cls, 2'b00, instr[FN_HI:FN_LO]};
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        ent_c.opcode  = {cls, 5'b00000};
        ent_c.illegal = 1'b1;
`else
        ent_c = '0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode with a two-entry skid buffer.
// Ports: clk, rst (async active-high), flush (sync discard), in_valid/
// in_ready/instr/rs_val (input beat), out_valid/out_ready (output
// handshake), opcode/reg1/reg2/label/immediate/illegal (decoded fields),
// illegal_seen (sticky, set when a trap entry is popped).
// DATA_W must lie in 32..64.
// Macro DECODE_ILLEGAL_TRAP_EN: enables trap decode of classes 110/111 and
// the illegal_seen status; otherwise both are tied 0.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_W    = 5,
  parameter bit          IMM_SEXT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        opcode,
  output logic [REG_W-1:0]  reg1,
  output logic [REG_W-1:0]  reg2,
  output logic [DATA_W-1:0] label,
  output logic [DATA_W-1:0] immediate,
  output logic              illegal,
  output logic              illegal_seen
);

  buf_state_e state_q;
  entry_t     dec_c;
  entry_t     head_q;
  entry_t     skid_q;
  logic       out_valid_q;
  logic       in_ready_q;
  logic       accept_c;
  logic       pop_c;

  decode_fields #(
    .DATA_W   (DATA_W),
    .IMM_SEXT (IMM_SEXT)
  ) u_fields (
    .instr (instr),
    .rs_val(rs_val),
    .ent_c (dec_c)
  );

  assign accept_c = in_valid & in_ready_q;
  assign pop_c    = out_valid_q & out_ready;

  // Buffer FSM: head_q drives the outputs, skid_q catches the beat accepted
  // while the head is stalled. in_ready_q mirrors (state != FULL).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            head_q      <= dec_c;
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept_c && pop_c) begin
            head_q <= dec_c;
          end else if (accept_c) begin
            skid_q     <= dec_c;
            state_q    <= ST_FULL;
            in_ready_q <= 1'b0;
          end else if (pop_c) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (pop_c) begin
            head_q     <= skid_q;
            state_q    <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_seen_q;

  // Sticky trap status: set when a trap entry leaves the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_seen_q <= 1'b0;
    end else if (flush) begin
      illegal_seen_q <= 1'b0;
    end else if (pop_c && head_q.illegal) begin
      illegal_seen_q <= 1'b1;
    end
  end

  assign illegal_seen = illegal_seen_q;
`else
  assign illegal_seen = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign opcode    = head_q.opcode;
  assign reg1      = REG_W'(head_q.reg1);
  assign reg2      = REG_W'(head_q.reg2);
  assign label     = DATA_W'(head_q.label);
  assign immediate = DATA_W'(head_q.immediate);
  assign illegal   = head_q.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, 32, width of rs_val, label and immediate outputs (>=32).
REQ-002 Parameter REG_W, 5, register-specifier width (fields fixed 5 bits, zero-extended to REG_W).
REQ-003 Parameter IMM_SEXT, 1, 1 = sign-extend immediate to DATA_W, 0 = zero-extend.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 flush  in  1  synchronous discard of all held entries.
REQ-008 in_valid  in  1  instr/rs_val valid.
REQ-009 in_ready  out  1  stage accepts a beat this cycle.
REQ-010 instr  in  32  instruction word.
REQ-011 rs_val  in  DATA_W  register value for register-jump class, sampled with instr.
REQ-012 out_valid  out  1  decoded fields valid.
REQ-013 out_ready  in  1  consumer accepts.
REQ-014 opcode  out  8; reg1, reg2  out  REG_W; label  out  DATA_W; immediate  out  DATA_W; illegal  out  1.
REQ-015 illegal_seen  out  1  sticky illegal status.

Function
REQ-016 Class = instr[31:29]; opcode[7:5] = class for all classes except 000, where opcode[7:4] = 0; unused fields = 0.
REQ-017 000: reg1=[28:24], reg2=[23:19], opcode[3:0]=[18:15].
REQ-018 001: reg1=[28:24], opcode[2:0]=[18:16], immediate=ext([15:0]).
REQ-019 010: reg2=[28:24], reg1=[23:19], opcode[2:0]=[18:16], immediate=ext([15:0]).
REQ-020 011: reg1=31, label=zero-ext([28:3]), opcode[2:0]=[2:0].
REQ-021 100: reg1=[28:24], label=zero-ext([21:0]), opcode[2:0]={0,[23:22]}.
REQ-022 101: reg1=[28:24], label=rs_val, opcode[2:0]=[18:16].
REQ-023 Decode combinational on input side; results registered; latency 1 cycle from accept to out_valid.
REQ-024 Two-entry skid buffer, states EMPTY, ONE, FULL; in_ready = (state != FULL), a function of state only.
REQ-025 Accept = in_valid & in_ready; pop = out_valid & out_ready; EMPTY->ONE on accept; ONE->FULL on accept without pop; ONE->EMPTY on pop without accept; FULL->ONE on pop; simultaneous accept+pop in ONE stays ONE.
REQ-026 Output fields stable while out_valid & !out_ready; order strictly FIFO.
REQ-027 flush: next state EMPTY, out_valid 0, in_valid that cycle dropped; flush overrides accept/pop.

Reset
REQ-028 rst asserted: state EMPTY, out_valid 0, all field outputs 0, illegal 0, illegal_seen 0, in_ready 1; deassert mid-transfer loses held entries.

Configuration
REQ-029 Macro DECODE_ILLEGAL_TRAP_EN defined: class 110/111 delivered with illegal=1, opcode[7:5]=class, other fields 0; illegal_seen set on pop of such entry, cleared by flush or rst.
REQ-030 Macro undefined: class 110/111 decoded as all-zero fields (NOP), illegal and illegal_seen tied 0.

Structure
REQ-031 Shared package holds class encodings (CLS_RTYPE..CLS_RJUMP), field bit positions, and the decoded-entry struct type.
REQ-032 Sub-module decode_fields: pure combinational class/field extraction; decode_stage owns buffer and handshake.

Verification
REQ-033 instr=0x01100000, out_ready=1 -> next cycle out_valid=1, reg1=1, reg2=2, opcode=0x00.
REQ-034 instr=0x2301FFFF, IMM_SEXT=1 -> opcode=0x21, reg1=3, immediate=0xFFFFFFFF; IMM_SEXT=0 -> 0x0000FFFF.
REQ-035 instr=0x6000002A then 0x84800010 -> (opcode=0x62, reg1=31, label=5), then (opcode=0x82, reg1=4, label=0x10).
REQ-036 instr=0xA5050000, rs_val=0x1234, out_ready=0 for 3 cycles with in_valid high -> in_ready low after 2 accepts, first entry label=0x1234 held, no loss on release.
REQ-037 FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped beat never appears.
REQ-038 With DECODE_ILLEGAL_TRAP_EN, instr=0xC0000000 -> illegal=1, opcode=0xC0, illegal_seen=1 after pop; without -> all-zero NOP, illegal=0.
